// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path:
// FSM states, opcodes, mux selects and the control word.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) ||
           (op == OP_BEQ) || (op == OP_ADDI) ||
           (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: maps the current state to the
// control word; unreachable encodings give an all-zero word.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_BR;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JEX: begin
        ctrl.pc_src   = PC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main control FSM: state register,
// next-state logic and the Moore output decode.
module multi_cycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_nxt = S_MEMADR;
          (opcode == OP_RTYPE): state_nxt = S_RTYPEEX;
          (opcode == OP_BEQ):   state_nxt = S_BEQEX;
          (opcode == OP_ADDI):  state_nxt = S_ADDIEX;
          (opcode == OP_J):     state_nxt = S_JEX;
          default:              state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        unique case (1'b1)
          (opcode == OP_LW): state_nxt = S_MEMRD;
          (opcode == OP_SW): state_nxt = S_MEMWR;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMRD:   state_nxt = S_MEMWB;
      S_RTYPEEX: state_nxt = S_RTYPEWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state (state),
    .ctrl  (ctrl)
  );

  assign alu_op     = ctrl.alu_op;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign pc_src     = ctrl.pc_src;
  assign state_dbg  = state;

  // branch is only ever set in BEQEX, so zero reaches pc_en there alone
  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign illegal_op = (state == S_DECODE) && !op_known(opcode);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: table vectors, reset corner
// cases and random instruction streams against a path model.
module tb_multi_cycle_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  typedef struct packed {
    logic [1:0] alu_op;
    logic       a;
    logic [1:0] b;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic [1:0] pcs;
    logic       pc_en;
    logic       ill;
    logic [3:0] st;
  } exp_t;

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         len;
    string      name;
  } vec_t;

  function automatic int lat(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  // k-th state visited by an instruction, starting at FETCH
  function automatic state_t st_at(input logic [5:0] op,
                                   input int k);
    state_t p[$];
    case (op)
      6'b100011: p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB};
      6'b101011: p = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
      6'b000000: p = '{S_FETCH, S_DECODE, S_RTYPEEX, S_RTYPEWB};
      6'b001000: p = '{S_FETCH, S_DECODE, S_ADDIEX, S_ADDIWB};
      6'b000100: p = '{S_FETCH, S_DECODE, S_BEQEX};
      6'b000010: p = '{S_FETCH, S_DECODE, S_JEX};
      default:   p = '{S_FETCH, S_DECODE};
    endcase
    if (k < p.size()) return p[k];
    return S_FETCH;
  endfunction

  function automatic exp_t expect_of(input state_t s,
                                     input logic [5:0] op,
                                     input logic z);
    exp_t e;
    e = '0;
    e.st = s;
    case (s)
      S_FETCH:   begin e.irw = 1; e.pc_en = 1; e.b = 2'b01; end
      S_DECODE:  begin
        e.b = 2'b11;
        e.ill = !(op inside {6'b100011, 6'b101011, 6'b000000,
                             6'b000100, 6'b001000, 6'b000010});
      end
      S_MEMADR:  begin e.a = 1; e.b = 2'b10; end
      S_MEMRD:   e.iord = 1;
      S_MEMWB:   begin e.m2r = 1; e.rw = 1; end
      S_MEMWR:   begin e.iord = 1; e.mw = 1; end
      S_RTYPEEX: begin e.a = 1; e.alu_op = 2'b10; end
      S_RTYPEWB: begin e.rd = 1; e.rw = 1; end
      S_BEQEX:   begin
        e.a = 1; e.alu_op = 2'b01; e.pcs = 2'b01; e.pc_en = z;
      end
      S_ADDIEX:  begin e.a = 1; e.b = 2'b10; end
      S_ADDIWB:  e.rw = 1;
      S_JEX:     begin e.pcs = 2'b10; e.pc_en = 1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input exp_t e, input string name);
    exp_t got;
    got = {alu_op, alu_src_a, alu_src_b, iord, mem_write,
           ir_write, reg_write, reg_dst, mem_to_reg, pc_src,
           pc_en, illegal_op, state_dbg};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got %h required %h (state %0d want %0d)",
               name, got, e, state_dbg, e.st);
    end
  endtask

  // Drives one instruction; opcode is valid only in DECODE and
  // MEMADR cycles and zero only in BEQEX, otherwise randomised.
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int len, input string name);
    int k;
    bit done;
    k = 0;
    done = 0;
    while (!done) begin
      opcode = (k == 1 || k == 2) ? op : 6'($urandom);
      zero   = (k == 2) ? z : 1'($urandom);
      @(negedge clk);
      check(expect_of(st_at(op, k), opcode, zero), name);
      k++;
      @(posedge clk); #1;
      if (state_dbg == S_FETCH || k >= 8) done = 1;
    end
    checks++;
    if (k != len) begin
      errors++;
      $display("FAIL %s_cycles: got %0d required %0d", name, k, len);
    end
  endtask

  // Reset asserted in the given cycle of an instruction
  task automatic reset_mid(input logic [5:0] op, input int at,
                           input string name);
    for (int k = 0; k < at; k++) begin
      opcode = op;
      zero = 1'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check(expect_of(st_at(op, at), op, zero), {name, "_pre"});
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check(expect_of(S_FETCH, op, zero), {name, "_post"});
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{6'b100011, 1'b0, 5, "lw"};
    vecs[1] = '{6'b101011, 1'b1, 4, "sw"};
    vecs[2] = '{6'b001000, 1'b0, 4, "addi"};
    vecs[3] = '{6'b000010, 1'b1, 3, "j"};
    vecs[4] = '{6'b000000, 1'b0, 4, "rtype"};
    vecs[5] = '{6'b000100, 1'b1, 3, "beq_taken"};
    vecs[6] = '{6'b000100, 1'b0, 3, "beq_not"};
    vecs[7] = '{6'b111111, 1'b0, 2, "illegal"};
    vecs[8] = '{6'b100011, 1'b1, 5, "lw_again"};

    rst_n = 0;
    opcode = 6'b000000;
    zero = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check(expect_of(S_FETCH, opcode, zero), "reset_state");
    @(posedge clk); #1;
    rst_n = 1;

    foreach (vecs[i])
      run_instr(vecs[i].op, vecs[i].z, vecs[i].len, vecs[i].name);

    reset_mid(6'b101011, 3, "rst_in_memwr");
    reset_mid(6'b100011, 3, "rst_in_memrd");
    reset_mid(6'b000000, 2, "rst_in_rtypeex");

    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] pool [6];
      pool = '{6'b100011, 6'b101011, 6'b000000,
               6'b000100, 6'b001000, 6'b000010};
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 5)];
      run_instr(op, 1'($urandom), lat(op), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameters: none; all encodings SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  in  1  reset; synchronous and active-low.
REQ-004 opcode  in  6  instruction[31:26], sampled from the instruction register.
REQ-005 zero  in  1  ALU zero flag, used for beq.
REQ-006 alu_op  out  2  to alu_control: 00 add, 01 branch compare, 10 funct-decoded; 11 never driven.
REQ-007 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-008 alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-009 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-010 mem_write, ir_write, reg_write  out  1 each  write strobes.
REQ-011 reg_dst  out  1  0 = rt, 1 = rd.
REQ-012 mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
REQ-013 pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 pc_en  out  1  pc_write OR (branch AND zero).
REQ-015 illegal_op  out  1  unknown opcode flag.
REQ-016 state_dbg  out  4  current state encoding.

Function
REQ-017 The block SHALL be a Moore FSM with one 4-bit state register; all outputs except pc_en and illegal_op SHALL decode from state only.
REQ-018 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-019 FETCH: iord=0, ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; next state DECODE.
REQ-020 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next state by opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> RTYPEEX
- 000100 -> BEQEX
- 001000 -> ADDIEX
- 000010 -> JEX
- any other opcode -> FETCH
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-022 MEMRD: iord=1 -> MEMWB.  MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
REQ-023 MEMWR: iord=1, mem_write=1 -> FETCH.
REQ-024 RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10 -> RTYPEWB.  RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-025 BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1 -> FETCH.
REQ-026 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDIWB.  ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
REQ-027 JEX: pc_src=10, pc_write=1 -> FETCH.
REQ-028 Any signal not listed for a state SHALL be 0, with no X values.
REQ-029 Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-030 pc_en SHALL be combinational; in BEQEX it SHALL follow zero in the same cycle.
REQ-031 illegal_op SHALL be 1 only while in DECODE with an unlisted opcode; the FSM then returns to FETCH with no write strobes asserted.
REQ-032 Unreachable state encodings SHALL transition to FETCH on the next edge, with all outputs 0.
REQ-033 opcode SHALL be ignored in every state except DECODE and MEMADR.

Reset
REQ-034 While rst_n=0 at a rising edge, state SHALL become FETCH, regardless of the current state (including reset mid-instruction).
REQ-035 The first cycle after reset SHALL present FETCH outputs; no write strobe other than FETCH's may be asserted.

Structure
REQ-036 A shared package (mips_pkg) SHALL hold:
- state encodings
- opcode constants
- alu_op codes 00/01/10
- alu_src_b and pc_src codes
REQ-037 Next-state logic and output decode SHALL be separate always blocks; a combinational sub-module mc_output_decode (state -> control word) is permitted.

Verification
REQ-038 lw (opcode 100011) after reset -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-039 beq (000100) with zero=1 -> pc_en=1 in BEQEX with pc_src=01; with zero=0 -> pc_en=0; back to FETCH either way.
REQ-040 R-type (000000) -> alu_op=10 in RTYPEEX, reg_dst=1 and reg_write=1 in RTYPEWB; 4 cycles total.
REQ-041 opcode 111111 -> illegal_op=1 for exactly one cycle in DECODE; next state FETCH; mem_write and reg_write never asserted.
REQ-042 rst_n=0 asserted during MEMWR -> the next state is FETCH, and mem_write is 0 in that cycle.
REQ-043 Back-to-back sw, addi, j -> cycle counts 4, 4, 3; alu_op never equals 11.
